// File: rtl/multdiv_ctrl_if.sv
// Start/operand/result bundle between the decode/execute stage and the
// iterative multiply/divide unit.
interface multdiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// One bit per cycle; fixed WIDTH+1 edge latency from start to result-ready.
module multdiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    multdiv_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIXUP, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    // acc carries one guard bit so the Booth shift keeps the true sign even
    // when adding/subtracting the most-negative multiplicand overflows WIDTH bits.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic             q1;
    logic [WIDTH-1:0] mcand;
    logic             is_div;
    logic             neg_res;
    logic             div_zero;
    logic             div_ovf;

    logic             accept;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_sub;
    logic             div_fit;

    assign accept = (bus.ctrl_MULT | bus.ctrl_DIV) && (state == IDLE || state == DONE);
    assign a_mag  = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign b_mag  = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    always_comb begin
        booth_sum = acc;
        case ({mq[0], q1})
            2'b01:   booth_sum = acc + {mcand[WIDTH-1], mcand};
            2'b10:   booth_sum = acc - {mcand[WIDTH-1], mcand};
            default: booth_sum = acc;
        endcase
    end

    assign div_sh  = {acc[WIDTH-1:0], mq[WIDTH-1]};
    assign div_fit = (div_sh >= {1'b0, mcand});
    assign div_sub = div_sh - {1'b0, mcand};

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            acc                <= '0;
            mq                 <= '0;
            q1                 <= 1'b0;
            mcand              <= '0;
            is_div             <= 1'b0;
            neg_res            <= 1'b0;
            div_zero           <= 1'b0;
            div_ovf            <= 1'b0;
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.data_resultRDY <= 1'b0;
                    state              <= IDLE;
                    if (accept) begin
                        cnt      <= '0;
                        acc      <= '0;
                        q1       <= 1'b0;
                        bus.busy <= 1'b1;
                        if (bus.ctrl_MULT) begin
                            is_div <= 1'b0;
                            mq     <= bus.data_operandB;
                            mcand  <= bus.data_operandA;
                            state  <= MULT;
                        end else begin
                            is_div   <= 1'b1;
                            mq       <= a_mag;
                            mcand    <= b_mag;
                            neg_res  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                            div_zero <= (bus.data_operandB == '0);
                            div_ovf  <= (bus.data_operandA == MIN_NEG) && (bus.data_operandB == '1);
                            state    <= DIV;
                        end
                    end
                end
                MULT: begin
                    {acc, mq, q1} <= {booth_sum[WIDTH], booth_sum, mq};
                    cnt           <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIXUP;
                end
                DIV: begin
                    acc <= div_fit ? div_sub : div_sh;
                    mq  <= {mq[WIDTH-2:0], div_fit};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIXUP;
                end
                FIXUP: begin
                    if (is_div) begin
                        bus.data_result    <= div_zero ? '0 : (neg_res ? -mq : mq);
                        bus.data_exception <= div_zero | div_ovf;
                    end else begin
                        bus.data_result    <= mq;
                        bus.data_exception <= (acc[WIDTH-1:0] != {WIDTH{mq[WIDTH-1]}});
                    end
                    bus.data_resultRDY <= 1'b1;
                    bus.busy           <= 1'b0;
                    state              <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: latency, busy window, Booth/restoring
// results, exceptions, ignored starts, mid-operation reset, back-to-back issue.
module tb_multdiv_ctrl;
    localparam int WIDTH = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    multdiv_ctrl_if #(.WIDTH(WIDTH)) bus ();

    multdiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
    endtask

    // Call with start already driven; consumes E0 and waits for RDY.
    // Leaves time at #1 after the RDY-rising edge so a back-to-back start can be driven.
    task automatic run_and_check(input string name, input logic [31:0] exp_res, input logic exp_exc);
        int busy_cnt = 0;
        int lat      = 0;
        bit got      = 0;
        @(posedge clock); #1;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        busy_cnt      = int'(bus.busy);
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clock); #1;
            if (bus.data_resultRDY) begin
                got = 1;
                lat = i;
            end else begin
                busy_cnt += int'(bus.busy);
            end
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges, expected 33", name, lat);
        end
        n_checks++;
        if (busy_cnt !== 33) begin
            n_fail++;
            $display("FAIL %s busy cycles: got %0d, expected 33", name, busy_cnt);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy in RDY cycle: got %b, expected 0", name, bus.busy);
        end
        n_checks++;
        if (bus.data_result !== exp_res) begin
            n_fail++;
            $display("FAIL %s result: got %h, expected %h", name, bus.data_result, exp_res);
        end
        n_checks++;
        if (bus.data_exception !== exp_exc) begin
            n_fail++;
            $display("FAIL %s exception: got %b, expected %b", name, bus.data_exception, exp_exc);
        end
    endtask

    task automatic expect_rdy_drop(input string name, input logic [31:0] exp_res);
        @(posedge clock); #1;
        n_checks++;
        if (bus.data_resultRDY !== 1'b0) begin
            n_fail++;
            $display("FAIL %s RDY width: got %b one cycle later, expected 0", name, bus.data_resultRDY);
        end
        n_checks++;
        if (bus.data_result !== exp_res) begin
            n_fail++;
            $display("FAIL %s result hold: got %h, expected %h", name, bus.data_result, exp_res);
        end
    endtask

    task automatic test_reset();
        issue(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got res=%h exc=%b rdy=%b busy=%b, expected all 0",
                     bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle busy: got %b, expected 0", bus.busy);
        end
    endtask

    task automatic test_mult();
        @(negedge clock); issue(1'b1, 1'b0, 32'd7, -32'sd3);
        run_and_check("mult_7x-3", 32'hFFFF_FFEB, 1'b0);
        expect_rdy_drop("mult_7x-3", 32'hFFFF_FFEB);
        @(negedge clock); issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        run_and_check("mult_ovf_2^32", 32'h0000_0000, 1'b1);
        @(negedge clock); issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000);
        run_and_check("mult_-1xmin", 32'h8000_0000, 1'b1);
        @(negedge clock); issue(1'b1, 1'b0, 32'h8000_0000, 32'd1);
        run_and_check("mult_minx1", 32'h8000_0000, 1'b0);
        @(negedge clock); issue(1'b1, 1'b1, -32'sd12, -32'sd11);
        run_and_check("mult_both_starts", 32'd132, 1'b0);
    endtask

    task automatic test_div();
        @(negedge clock); issue(1'b0, 1'b1, -32'sd100, 32'd7);
        run_and_check("div_-100/7", 32'hFFFF_FFF2, 1'b0);
        @(negedge clock); issue(1'b0, 1'b1, 32'd5, 32'd0);
        run_and_check("div_by_zero", 32'd0, 1'b1);
        @(negedge clock); issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_and_check("div_min/-1", 32'h8000_0000, 1'b1);
        @(negedge clock); issue(1'b0, 1'b1, 32'd100, -32'sd7);
        run_and_check("div_100/-7", 32'hFFFF_FFF2, 1'b0);
        @(negedge clock); issue(1'b0, 1'b1, -32'sd99, -32'sd10);
        run_and_check("div_-99/-10", 32'd9, 1'b0);
    endtask

    task automatic test_ignored_start();
        int pulses = 0;
        int lat    = 0;
        logic [31:0] res = '0;
        @(negedge clock); issue(1'b0, 1'b1, 32'd100, 32'd7);
        @(posedge clock); #1;
        issue(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 1; i <= 45; i++) begin
            @(posedge clock); #1;
            if (i == 10) issue(1'b1, 1'b0, 32'd3, 32'd3);
            if (i == 11) issue(1'b0, 1'b0, 32'd0, 32'd0);
            if (bus.data_resultRDY) begin
                pulses++;
                if (pulses == 1) begin
                    lat = i;
                    res = bus.data_result;
                end
            end
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL ignored_start pulses: got %0d, expected 1", pulses);
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL ignored_start latency: got %0d, expected 33", lat);
        end
        n_checks++;
        if (res !== 32'd14) begin
            n_fail++;
            $display("FAIL ignored_start result: got %h, expected %h", res, 32'd14);
        end
    endtask

    task automatic test_reset_midop_and_back_to_back();
        int pulses = 0;
        @(negedge clock); issue(1'b1, 1'b0, 32'd9, 32'd9);
        @(posedge clock); #1;
        issue(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (20) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy} !== 35'd0) begin
            n_fail++;
            $display("FAIL midop_reset outputs: got res=%h exc=%b rdy=%b busy=%b, expected all 0",
                     bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (bus.data_resultRDY || bus.busy) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL midop_reset abandoned op: got %0d active cycles, expected 0", pulses);
        end
        @(negedge clock); issue(1'b1, 1'b0, 32'd6, 32'd7);
        run_and_check("mult_6x7", 32'd42, 1'b0);
        issue(1'b0, 1'b1, 32'd42, 32'd6);
        run_and_check("b2b_div_42/6", 32'd7, 1'b0);
        expect_rdy_drop("b2b_div_42/6", 32'd7);
    endtask

    initial begin
        issue(1'b0, 1'b0, 32'd0, 32'd0);
        test_reset();
        test_mult();
        test_div();
        test_ignored_start();
        test_reset_midop_and_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Iterative signed multiply/divide unit for the processor's mult/div ALU opcodes. The decode stage asserts a one-cycle start pulse with two 32-bit operands. The block runs a radix-2 Booth multiply or a restoring divide over WIDTH iterations and returns a result with an exception flag. It also drives `busy`, which the pipeline uses to stall the execute stage for mult/div instructions while the main ALU stays free for other ops.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- ctrl_MULT  input  1  one-cycle start pulse for signed multiply.
- ctrl_DIV  input  1  one-cycle start pulse for signed divide.
- data_operandA  input  WIDTH  multiplicand / dividend; sampled only on an accepted start.
- data_operandB  input  WIDTH  multiplier / divisor; sampled only on an accepted start.
- data_result  output  WIDTH  registered result; holds until the next completion.
- data_exception  output  1  registered exception flag; valid with data_resultRDY, holds with data_result.
- data_resultRDY  output  1  high for exactly one cycle when the result is valid.
- busy  output  1  high from the cycle after an accepted start through the fixup cycle.

## Operation
- States: IDLE, MULT, DIV, FIXUP, DONE.
- A start is accepted only in IDLE or DONE. On acceptance, latch the operands, clear the iteration counter, and go to MULT or DIV.
- ctrl_MULT and ctrl_DIV asserted together: treated as MULT.
- Start pulses in MULT, DIV or FIXUP are ignored entirely; latched operands and the counter are unchanged.
- MULT: radix-2 Booth on a {WIDTH-bit acc, WIDTH-bit multiplier, 1-bit q-1} register, with an arithmetic shift right each iteration. After WIDTH iterations go to FIXUP.
- DIV: restoring division on the magnitudes of A and B, one quotient bit per iteration. Signs are recorded at start. After WIDTH iterations go to FIXUP.
- FIXUP, multiply: result is the low WIDTH bits of the 2*WIDTH-bit product. Exception = 1 if the high WIDTH bits are not all equal to bit WIDTH-1 of the product (signed overflow).
- FIXUP, divide: quotient truncates toward zero and is negated if the operand signs differ. Remainder is discarded.
- Divide by zero (B == 0): result = 0, exception = 1.
- A = 0x80000000, B = -1: result = 0x80000000, exception = 1.
- FIXUP → DONE: registers data_result and data_exception and pulses data_resultRDY.
- DONE → IDLE after one cycle unless a new start is accepted, in which case it goes directly to MULT or DIV.
- Reset (asynchronous, any state): state = IDLE. data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0, internal registers 0. An in-flight operation is abandoned and never produces data_resultRDY.

## Timing
- Edge E0 samples the start. busy = 1 from E0 through E1+WIDTH (the FIXUP edge).
- Iterations occur on edges E1..E(WIDTH).
- FIXUP occupies the cycle ending at E(WIDTH+1).
- data_resultRDY is high in the cycle after E(WIDTH+1), i.e. the output goes high at E(WIDTH+1) and low at E(WIDTH+2).
- Latency from the start edge to RDY rising is WIDTH+1 edges (33 for WIDTH = 32), identical for all cases including exceptions.
- Back-to-back: a start asserted while data_resultRDY = 1 is accepted on that edge. busy returns high immediately on the next cycle. Throughput is one operation per WIDTH+2 cycles.
- data_result and data_exception change only at the FIXUP edge or on reset.

## Test plan
- MULT A = 7, B = -3 → after 33 edges: RDY one cycle, data_result = 0xFFFFFFEB, exception = 0. busy high for exactly 33 cycles.
- MULT A = 0x00010000, B = 0x00010000 → data_result = 0x00000000, exception = 1. MULT A = -1, B = 0x80000000 → data_result = 0x80000000, exception = 1.
- DIV A = -100, B = 7 → data_result = 0xFFFFFFF2 (-14), exception = 0. DIV A = 5, B = 0 → data_result = 0, exception = 1 with the same 33-edge latency.
- DIV A = 0x80000000, B = 0xFFFFFFFF → data_result = 0x80000000, exception = 1.
- Start DIV 100/7, then pulse ctrl_MULT with new operands at iteration 10 → ignored. Result = 14, only one RDY pulse.
- Assert reset at iteration 20 of MULT 9*9 → all outputs 0 immediately, no RDY. Then MULT 6*7 → result 42 after 33 edges. Issue a DIV 42/6 in the RDY cycle → accepted, result 7 after 33 more edges.
